// File: rtl/cpu_pkg.sv
// Shared CPU package: loader FSM state encoding, word geometry and the
// partial-word padding helper used by the instruction-memory loader.
package cpu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone,
    StErr
  } ld_state_e;

  // Left-justify a partially assembled word: 'w' holds (nbytes_m1 + 1) bytes
  // in its low-order bytes; the unfilled low-order bytes become zero.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] nbytes_m1);
    int unsigned sh;
    sh = 8 * (WORD_BYTES - 1 - int'(nbytes_m1));
    return w << sh;
  endfunction

endpackage

// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a byte stream (MSB first) into 32-bit
// words and writes them to consecutive instruction-memory addresses.
//   clk, reset_n                 : clock, async active-low reset
//   start                        : pulse, begins a session (ignored in LOAD/FLUSH)
//   byte_valid/data/last, ready  : byte stream handshake; last marks image end
//   im_we, im_addr, im_wdata     : registered one-cycle word write
//   busy, done, overflow         : session status
//   word_count                   : words written this session
module im_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  // Pointer value one past the last valid address; reaching it means full.
  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0] LastByte = 2'(WORD_BYTES - 1);

  ld_state_e         state_q, state_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] shifted;
  logic        xfer;

  assign shifted = {asm_q[23:0], byte_data};
  assign xfer    = byte_valid && (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLoad;
          asm_d   = '0;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          asm_d = shifted;
          cnt_d = cnt_q + 2'd1;
          // A word is attempted on its 4th byte, or early on the final byte.
          if ((cnt_q == LastByte) || byte_last) begin
            if (ptr_q == Depth) begin
              state_d = StErr;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q[ADDR_W-1:0];
              wdata_d = (cnt_q == LastByte) ? shifted : pad_word(shifted, cnt_q);
              ptr_d   = ptr_q + (ADDR_W + 1)'(1);
              if (byte_last) begin
                // The registered strobe of the final word lands in FLUSH.
                state_d = StFlush;
              end
            end
          end
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      asm_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign byte_ready = (state_q == StLoad);
  assign busy       = (state_q == StLoad) || (state_q == StFlush);
  assign done       = (state_q == StDone);
  assign overflow   = (state_q == StErr);
  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign word_count = ptr_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a default-size instance (ADDR_W=10) and a tiny one
// (ADDR_W=2) for overflow; directed sessions plus random byte streams,
// checked against a word-grouping reference model.
module tb_im_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_v, valid_v, last_v;
  logic [7:0] data_v;
  int         sel;

  always #5 clk = ~clk;

  // Big instance
  logic        start_b, valid_b, ready_b, we_b, busy_b, done_b, ovf_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b;
  logic [10:0] wc_b;
  // Small instance
  logic        start_s, valid_s, ready_s, we_s, busy_s, done_s, ovf_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  wc_s;

  assign start_b = start_v && (sel == 0);
  assign valid_b = valid_v && (sel == 0);
  assign start_s = start_v && (sel == 1);
  assign valid_s = valid_v && (sel == 1);

  im_loader #(.ADDR_W(10)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .byte_valid(valid_b),
    .byte_data(data_v), .byte_last(last_v), .byte_ready(ready_b), .im_we(we_b),
    .im_addr(addr_b), .im_wdata(wdata_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .word_count(wc_b)
  );

  im_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start_s), .byte_valid(valid_s),
    .byte_data(data_v), .byte_last(last_v), .byte_ready(ready_s), .im_we(we_s),
    .im_addr(addr_s), .im_wdata(wdata_s), .busy(busy_s), .done(done_s),
    .overflow(ovf_s), .word_count(wc_s)
  );

  // Observation of the selected instance
  logic        o_we, o_ready, o_busy, o_done, o_ovf;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [10:0] o_wc;

  always_comb begin
    if (sel == 0) begin
      o_we = we_b; o_ready = ready_b; o_busy = busy_b; o_done = done_b; o_ovf = ovf_b;
      o_addr = addr_b; o_wdata = wdata_b; o_wc = wc_b;
    end else begin
      o_we = we_s; o_ready = ready_s; o_busy = busy_s; o_done = done_s; o_ovf = ovf_s;
      o_addr = {8'b0, addr_s}; o_wdata = wdata_s; o_wc = {8'b0, wc_s};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writes seen on the selected instance
  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (reset_n && o_we) begin
      got_addr.push_back(o_addr);
      got_data.push_back(o_wdata);
    end
  end

  // Reference model: group the byte stream into words, zero-pad the tail,
  // keep only the words that fit in the memory.
  logic [7:0]  stim[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_ovf;
  int          exp_wc;

  task automatic model_session(input int depth);
    int n, nwords;
    logic [31:0] w;
    n = stim.size();
    nwords = (n + 3) / 4;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < nwords && i < depth; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = w << 8;
        if (4 * i + k < n) w = w | {24'h0, stim[4 * i + k]};
      end
      exp_addr.push_back(10'(i));
      exp_data.push_back(w);
    end
    exp_ovf = (nwords > depth);
    exp_wc  = (nwords > depth) ? depth : nwords;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    valid_v = 1'b1;
    data_v  = b;
    last_v  = last;
    t = 0;
    while (!o_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) check_eq("ready_timeout", 64'(o_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid_v = 1'b0;
    last_v  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
  endtask

  // gapmode: 0 back-to-back, 1 every other cycle, 2 random; mid: byte index
  // before which a stray start is pulsed (-1 for none).
  task automatic run_session(input int s, input int gapmode, input int mid, input string nm);
    int t, gap;
    sel = s;
    model_session(s == 0 ? 1024 : 4);
    got_addr.delete();
    got_data.delete();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      if (i == mid) pulse_start();
      gap = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(stim[i], i == stim.size() - 1, gap);
    end
    t = 0;
    while (o_busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq({nm, ":nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_eq({nm, ":addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
      check_eq({nm, ":data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
    check_eq({nm, ":done"}, 64'(o_done), 64'(!exp_ovf));
    check_eq({nm, ":overflow"}, 64'(o_ovf), 64'(exp_ovf));
    check_eq({nm, ":word_count"}, 64'(o_wc), 64'(exp_wc));
    check_eq({nm, ":busy"}, 64'(o_busy), 64'd0);
    check_eq({nm, ":ready"}, 64'(o_ready), 64'd0);
  endtask

  task automatic fill_seq(input int n, input int base);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'(base + i));
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_idle_outputs(input string nm);
    check_eq({nm, ":we"}, 64'({we_b, we_s}), 64'd0);
    check_eq({nm, ":ready"}, 64'({ready_b, ready_s}), 64'd0);
    check_eq({nm, ":flags"}, 64'({busy_b, done_b, ovf_b, busy_s, done_s, ovf_s}), 64'd0);
    check_eq({nm, ":addr"}, 64'({addr_b, addr_s}), 64'd0);
    check_eq({nm, ":wdata"}, {wdata_b, wdata_s}, 64'd0);
    check_eq({nm, ":wc"}, 64'({wc_b, wc_s}), 64'd0);
  endtask

  initial begin
    sel = 0; start_v = 0; valid_v = 0; last_v = 0; data_v = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    stim.delete();
    stim.push_back(8'h12); stim.push_back(8'h34); stim.push_back(8'h56); stim.push_back(8'h78);
    run_session(0, 0, -1, "one_word");

    fill_seq(8, 8'hA0);
    run_session(0, 1, -1, "toggle8");

    fill_seq(5, 1);
    run_session(0, 0, -1, "flush5");

    stim.delete();
    stim.push_back(8'hAA); stim.push_back(8'hBB);
    run_session(0, 0, -1, "pad2");

    fill_seq(17, 8'h40);
    run_session(1, 0, -1, "overflow17");

    fill_seq(11, 8'h60);
    run_session(0, 0, 6, "start_mid");

    // Reset mid-session discards the partial word
    sel = 0;
    fill_seq(6, 8'hC0);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stim[i], 1'b0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    fill_seq(4, 8'hD1);
    run_session(0, 0, -1, "after_reset");

    for (int r = 0; r < 6; r++) begin
      fill_rand(int'($urandom_range(1, 40)));
      run_session(0, 2, -1, "rand_big");
    end
    for (int r = 0; r < 4; r++) begin
      fill_rand(int'($urandom_range(1, 20)));
      run_session(1, 2, -1, "rand_small");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the word-address width of the instruction memory written (depth 2^ADDR_W words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: single-cycle pulse that begins a load session.
REQ-005 SHALL have port byte_valid, input, 1: byte_data is offered.
REQ-006 SHALL have port byte_data, input, 8: stream byte, most-significant byte of each word first.
REQ-007 SHALL have port byte_last, input, 1: qualifies the final byte of the image.
REQ-008 SHALL have port byte_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 SHALL have port im_we, output, 1: word write strobe to the instruction memory.
REQ-010 SHALL have port im_addr, output, ADDR_W: word address of the write.
REQ-011 SHALL have port im_wdata, output, 32: word written.
REQ-012 SHALL have port busy, output, 1: a session is in progress.
REQ-013 SHALL have port done, output, 1: the image loaded completely.
REQ-014 SHALL have port overflow, output, 1: the image exceeded 2^ADDR_W words.
REQ-015 SHALL have port word_count, output, ADDR_W+1: words written this session.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH, DONE, ERR.
- IDLE/DONE/ERR --start--> LOAD
- LOAD --last byte--> FLUSH
- FLUSH --> DONE after one cycle
- LOAD --word attempted at address 2^ADDR_W--> ERR
REQ-017 SHALL transfer a byte only when byte_valid and byte_ready are both high in the same cycle.
REQ-018 SHALL drive byte_ready high only in LOAD.
REQ-019 SHALL shift accepted bytes into a 32-bit assembly register, left-shifted, with a 2-bit byte counter.
REQ-020 SHALL, on the 4th byte of a word, pulse im_we for exactly one cycle in the next cycle, with im_wdata holding the assembled word and im_addr equal to the current write pointer.
REQ-021 SHALL increment the write pointer and word_count after each write.
REQ-022 SHALL, when byte_last arrives on a partial word, zero-pad the remaining low-order bytes and write that word in FLUSH.
- Example: bytes AA,BB then last -> 0xAABB0000.
REQ-023 SHALL write no extra word in FLUSH when byte_last completes a full word.
REQ-024 SHALL, if a word would be written at pointer 2^ADDR_W, suppress im_we, set overflow, and enter ERR.
- The pointer SHALL NOT wrap.
REQ-025 SHALL, on start in any non-LOAD state:
- clear the pointer, word_count, byte counter, done and overflow;
- ignore start while in LOAD or FLUSH.
REQ-026 SHALL hold busy high in LOAD and FLUSH and low otherwise.
REQ-027 SHALL assert done in DONE until the next start; overflow likewise in ERR.
REQ-028 SHALL drive im_we low in all cycles other than the write cycles of REQ-020 and REQ-022.

Reset
REQ-029 SHALL on reset_n low immediately force:
- state IDLE;
- byte_ready, im_we, busy, done and overflow to 0;
- im_addr, im_wdata and word_count to 0;
- any partial word discarded, including when reset occurs mid-session.

Structure
REQ-030 SHALL place the state encoding and the WORD_BYTES=4 constant in the shared cpu package; ADDR_W stays a module parameter.
REQ-031 SHALL be a single module with no sub-modules; the byte assembler is inline logic.

Verification
REQ-032 SHALL cover these directed scenarios:
- start, bytes 12,34,56,78 (last on 78) -> one write addr0 data 0x12345678, done=1, word_count=1.
- 8 bytes, byte_valid toggled every other cycle -> writes at addr0 and addr1 with correct words, no stray im_we.
- 5 bytes 01..05, last on 05 -> 0x01020304 at addr0, 0x05000000 at addr1 via FLUSH, word_count=2.
- ADDR_W=2, 17 bytes -> 4 writes, overflow=1, no 5th im_we, byte_ready=0 in ERR.
- reset_n low after 6 bytes, then start and 4 bytes -> the single write is at addr0 and contains only the new bytes.
- start pulsed mid-LOAD -> ignored, pointer and session unaffected.
